// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR bus initiator bridge; one transaction in flight.
// Optional macro WB_CSR_BRIDGE_POSTED_WRITE_EN acks writes on the accepting edge.
module wb_csr_bridge #(
  parameter int unsigned read_latency = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_do,
  input  logic [31:0] csr_di
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   wb_dat_nxt, csr_do_nxt;
  logic [ADDR_W-1:0]   csr_a_nxt;
  logic                wb_ack_nxt, csr_we_nxt;
  logic                req_c, last_c;

  assign req_c  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign last_c = (cnt == CNT_W'(read_latency - 1));

  // State and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      csr_a    <= '0;
      csr_we   <= 1'b0;
      csr_do   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wb_ack_o <= wb_ack_nxt;
      wb_dat_o <= wb_dat_nxt;
      csr_a    <= csr_a_nxt;
      csr_we   <= csr_we_nxt;
      csr_do   <= csr_do_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_c) begin
`ifdef WB_CSR_BRIDGE_POSTED_WRITE_EN
          state_nxt = wb_we_i ? ACK : READ;
`else
          state_nxt = wb_we_i ? WRITE : READ;
`endif
        end
      end
      WRITE:   state_nxt = ACK;
      READ:    if (last_c) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the read wait counter
  always_comb begin
    cnt_nxt    = cnt;
    wb_ack_nxt = 1'b0;
    wb_dat_nxt = wb_dat_o;
    csr_a_nxt  = csr_a;
    csr_we_nxt = 1'b0;
    csr_do_nxt = csr_do;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_c) begin
          csr_a_nxt  = wb_adr_i[15:2];
          csr_do_nxt = wb_dat_i;
          csr_we_nxt = wb_we_i;
`ifdef WB_CSR_BRIDGE_POSTED_WRITE_EN
          wb_ack_nxt = wb_we_i;
`endif
        end
      end
      WRITE: wb_ack_nxt = 1'b1;
      READ: begin
        if (last_c) begin
          wb_dat_nxt = csr_di;
          wb_ack_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ACK:     ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Directed bench for wb_csr_bridge: read_latency 1 and 3 instances side by side.
// Honors WB_CSR_BRIDGE_POSTED_WRITE_EN to select write-timing expectations.
module tb_wb_csr_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] csr_di1, csr_di3;

  logic [31:0] wb_dat_o1, wb_dat_o3, csr_do1, csr_do3;
  logic        wb_ack_o1, wb_ack_o3, csr_we1, csr_we3;
  logic [13:0] csr_a1, csr_a3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  wb_csr_bridge #(.read_latency(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o1),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o1), .csr_a(csr_a1), .csr_we(csr_we1),
    .csr_do(csr_do1), .csr_di(csr_di1)
  );

  wb_csr_bridge #(.read_latency(3)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o3),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o3), .csr_a(csr_a3), .csr_we(csr_we3),
    .csr_do(csr_do3), .csr_di(csr_di3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;
  endtask

  task automatic drop();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    csr_di1 = '0; csr_di3 = '0;
    req(1'b1, 32'h0000_0414, 32'hDEAD_BEEF);

    // Reset held with strobe asserted
    repeat (3) tick();
    check("rst_ack",    32'(wb_ack_o1), 32'h0);
    check("rst_dat_o",  wb_dat_o1,      32'h0);
    check("rst_csr_a",  32'(csr_a1),    32'h0);
    check("rst_csr_we", 32'(csr_we1),   32'h0);
    check("rst_csr_do", csr_do1,        32'h0);

    // Release: write accepted in the very next cycle
    sys_rst_n = 1'b1;
    tick();
    check("wr_csr_a",  32'(csr_a1), 32'h0000_0105);
    check("wr_csr_do", csr_do1,     32'hDEAD_BEEF);
    check("wr_we_c1",  32'(csr_we1), 32'h1);
    drop();
`ifdef WB_CSR_BRIDGE_POSTED_WRITE_EN
    check("wr_ack_c1", 32'(wb_ack_o1), 32'h1);
    tick();
    check("wr_we_c2",  32'(csr_we1),   32'h0);
    check("wr_ack_c2", 32'(wb_ack_o1), 32'h0);
`else
    check("wr_ack_c1", 32'(wb_ack_o1), 32'h0);
    tick();
    check("wr_we_c2",  32'(csr_we1),   32'h0);
    check("wr_ack_c2", 32'(wb_ack_o1), 32'h1);
    tick();
    check("wr_ack_c3", 32'(wb_ack_o1), 32'h0);
`endif
    check("wr_dat_hold", wb_dat_o1, 32'h0);
    repeat (2) tick();

    // Read: latency 1 on dut1, latency 3 with an early junk word on dut3
    req(1'b0, 32'h0000_0008, 32'h0);
    tick();
    check("rd_csr_a",   32'(csr_a1),  32'h2);
    check("rd_we1",     32'(csr_we1), 32'h0);
    check("rd_ack1_c1", 32'(wb_ack_o1), 32'h0);
    drop();
    csr_di1 = 32'h1234_5678;
    tick();
    check("rd_ack1_c2", 32'(wb_ack_o1), 32'h1);
    check("rd_dat1",    wb_dat_o1,      32'h1234_5678);
    check("rd_ack3_c2", 32'(wb_ack_o3), 32'h0);
    csr_di1 = 32'h0;
    csr_di3 = 32'hFFFF_FFFF;
    tick();
    check("rd_ack1_c3", 32'(wb_ack_o1), 32'h0);
    check("rd_ack3_c3", 32'(wb_ack_o3), 32'h0);
    check("rd_we3",     32'(csr_we3),   32'h0);
    csr_di3 = 32'hCAFE_F00D;
    tick();
    check("rd_ack3_c4", 32'(wb_ack_o3), 32'h1);
    check("rd_dat3",    wb_dat_o3,      32'hCAFE_F00D);
    csr_di3 = 32'h0;
    tick();
    check("rd_ack3_c5", 32'(wb_ack_o3), 32'h0);
    check("rd_dat3_hold", wb_dat_o3,    32'hCAFE_F00D);
    check("rd_dat1_hold", wb_dat_o1,    32'h1234_5678);
    tick();

    // Upper and low address bits ignored; write leaves read data alone
    req(1'b1, 32'hABCD_FFFF, 32'h0BAD_F00D);
    tick();
    drop();
    check("trunc_csr_a", 32'(csr_a1), 32'h0000_3FFF);
    repeat (3) tick();
    check("trunc_dat_hold", wb_dat_o1, 32'h1234_5678);
    check("trunc_csr_a_hold", 32'(csr_a1), 32'h0000_3FFF);
    check("trunc_csr_do_hold", csr_do1, 32'h0BAD_F00D);

    // Reset during the read wait on dut3
    req(1'b0, 32'h0000_0010, 32'h0);
    tick();
    drop();
    tick();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    check("mrst_ack",   32'(wb_ack_o3), 32'h0);
    check("mrst_dat_o", wb_dat_o3,      32'h0);
    check("mrst_csr_a", 32'(csr_a3),    32'h0);
    tick();
    check("mrst_ack_p1", 32'(wb_ack_o3), 32'h0);
    tick();
    check("mrst_ack_p2", 32'(wb_ack_o3), 32'h0);

    // Back in IDLE: a fresh read completes with normal latency
    csr_di3 = 32'h55AA_55AA;
    req(1'b0, 32'h0000_000C, 32'h0);
    tick();
    drop();
    repeat (2) tick();
    check("post_rst_ack_c3", 32'(wb_ack_o3), 32'h0);
    tick();
    check("post_rst_ack_c4", 32'(wb_ack_o3), 32'h1);
    check("post_rst_dat",    wb_dat_o3,      32'h55AA_55AA);
    repeat (2) tick();

`ifdef WB_CSR_BRIDGE_POSTED_WRITE_EN
    // Posted back-to-back: second write accepted in cycle 3, pulses in cycles 1 and 4
    req(1'b1, 32'h0000_0004, 32'h1);
    tick();
    drop();
    check("b2b_we_c1",  32'(csr_we1),   32'h1);
    check("b2b_ack_c1", 32'(wb_ack_o1), 32'h1);
    tick();
    check("b2b_we_c2",  32'(csr_we1),   32'h0);
    check("b2b_ack_c2", 32'(wb_ack_o1), 32'h0);
    tick();
    check("b2b_we_c3",  32'(csr_we1),   32'h0);
    check("b2b_ack_c3", 32'(wb_ack_o1), 32'h0);
    req(1'b1, 32'h0000_0004, 32'h2);
    tick();
    drop();
    check("b2b_we_c4",  32'(csr_we1),   32'h1);
    check("b2b_ack_c4", 32'(wb_ack_o1), 32'h1);
    check("b2b_do_c4",  csr_do1,        32'h2);
    tick();
    check("b2b_ack_c5", 32'(wb_ack_o1), 32'h0);
`else
    // Non-posted with strobe held: second write accepted once ACK has cleared
    req(1'b1, 32'h0000_0004, 32'h1);
    tick();
    check("b2b_we_c1",  32'(csr_we1),   32'h1);
    tick();
    check("b2b_ack_c2", 32'(wb_ack_o1), 32'h1);
    check("b2b_we_c2",  32'(csr_we1),   32'h0);
    wb_dat_i = 32'h2;
    tick();
    check("b2b_ack_c3", 32'(wb_ack_o1), 32'h0);
    check("b2b_we_c3",  32'(csr_we1),   32'h0);
    tick();
    drop();
    check("b2b_we_c4",  32'(csr_we1),   32'h1);
    check("b2b_do_c4",  csr_do1,        32'h2);
    tick();
    check("b2b_ack_c5", 32'(wb_ack_o1), 32'h1);
    tick();
    check("b2b_ack_c6", 32'(wb_ack_o1), 32'h0);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_csr_bridge.md
WB_CSR_BRIDGE -- requirements
Module: wb_csr_bridge

Interface
REQ-001 Parameter read_latency, default 1, meaning: clock edges from csr_a/csr_we=0 presented to csr_di valid; legal range 1..3.
REQ-002 sys_clk  input  1  single clock; all logic on rising edge.
REQ-003 sys_rst_n  input  1  reset; synchronous, active-low.
REQ-004 wb_adr_i  input  32  Wishbone word address source; bits [15:2] used.
REQ-005 wb_dat_i  input  32  Wishbone write data.
REQ-006 wb_dat_o  output  32  Wishbone read data, registered.
REQ-007 wb_cyc_i  input  1  Wishbone cycle.
REQ-008 wb_stb_i  input  1  Wishbone strobe.
REQ-009 wb_we_i  input  1  Wishbone write enable.
REQ-010 wb_ack_o  output  1  Wishbone acknowledge, registered, one-cycle pulse.
REQ-011 csr_a  output  14  CSR address to all slaves (bank [13:10], register [9:0]), registered.
REQ-012 csr_we  output  1  CSR write strobe, registered, one-cycle pulse.
REQ-013 csr_do  output  32  CSR write data to slaves, registered.
REQ-014 csr_di  input  32  OR of all slaves' read data; unselected slaves drive zero.

Function
REQ-015 The bridge SHALL be the sole CSR bus initiator, implemented as FSM with states IDLE, WRITE, READ, ACK.
REQ-016 In IDLE with wb_cyc_i & wb_stb_i & ~wb_ack_o, the bridge SHALL latch csr_a<=wb_adr_i[15:2], csr_do<=wb_dat_i, csr_we<=wb_we_i, and go to WRITE if wb_we_i else READ.
REQ-017 WRITE: csr_we SHALL be high exactly one cycle; next edge SHALL clear csr_we, set wb_ack_o, enter ACK.
REQ-018 READ: csr_we SHALL stay low; a wait counter SHALL count read_latency edges from entry; on the final edge wb_dat_o<=csr_di, wb_ack_o<=1, enter ACK.
REQ-019 ACK: next edge SHALL clear wb_ack_o and return to IDLE; wb_ack_o SHALL never be high two consecutive cycles.
REQ-020 Read ack SHALL occur read_latency+1 cycles after the accepting cycle; write ack 2 cycles after (non-posted).
REQ-021 wb_dat_o SHALL change only on read completion; writes and idle cycles SHALL hold it.
REQ-022 csr_a and csr_do SHALL hold their last values between transactions; csr_we SHALL be low outside the single write cycle.
REQ-023 Deassertion of wb_cyc_i or wb_stb_i mid-transaction SHALL NOT abort it; the CSR access completes and the ack is still issued.
REQ-024 wb_adr_i bits [31:16] and [1:0] SHALL be ignored; address wrap is by truncation.

Reset
REQ-025 While sys_rst_n=0 at an edge: state<=IDLE, wait counter<=0, wb_ack_o<=0, wb_dat_o<=0, csr_a<=0, csr_we<=0, csr_do<=0.
REQ-026 Reset mid-transaction SHALL abort it with no ack and no further csr_we pulse.

Configuration
REQ-027 Macro WB_CSR_BRIDGE_POSTED_WRITE_EN defined: on accepting a write in IDLE, the same edge SHALL set csr_we<=1 and wb_ack_o<=1 and enter ACK (write ack 1 cycle after acceptance; csr_we and wb_ack_o high in the same cycle); WRITE state unused.
REQ-028 Macro undefined: writes follow REQ-017 exactly; reads unaffected either way.

Verification
REQ-029 Reset: hold sys_rst_n=0 with wb_stb_i=1 -> all outputs 0, no ack; release -> transaction accepted next cycle.
REQ-030 Write adr=0x0000_0414, dat=0xDEADBEEF, macro off -> csr_a=0x105, csr_do=0xDEADBEEF, csr_we high exactly 1 cycle, wb_ack_o 2 cycles after accept.
REQ-031 Read adr=0x0000_0008, read_latency=1, model slave returns 0x12345678 one edge after address -> wb_dat_o=0x12345678 with wb_ack_o 2 cycles after accept; csr_we never high.
REQ-032 read_latency=3, slave delayed accordingly -> ack 4 cycles after accept with correct data; csr_di value 0xFFFFFFFF present only in an earlier cycle -> not captured.
REQ-033 Macro on, back-to-back writes 0x1, 0x2 -> csr_we pulses in cycles 1 and 4 relative to first accept, one ack per write, no double ack.
REQ-034 sys_rst_n pulsed low in READ wait cycle -> no ack, wb_dat_o=0, FSM in IDLE.
